// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: data width, the alu_control
// op codes driven by the ALU-control decoder, and the execution FSM states.
package alu_pkg;

    localparam int ALU_DATA_W  = 32;
    localparam int ALU_SHAMT_W = 5;

    // alu_control op codes; 5 and 9..15 are unused and produce zero.
    localparam logic [3:0] AND_OP = 4'd0;
    localparam logic [3:0] OR_OP  = 4'd1;
    localparam logic [3:0] ADD_OP = 4'd2;
    localparam logic [3:0] SLL_OP = 4'd3;
    localparam logic [3:0] SRL_OP = 4'd4;
    localparam logic [3:0] SUB_OP = 4'd6;
    localparam logic [3:0] SLT_OP = 4'd7;
    localparam logic [3:0] MUL_OP = 4'd8;

    // Execution FSM: IDLE handles single-cycle ops; MUL1/MUL2 cover the
    // two extra cycles of the pipelined multiply.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_mult.sv
// Two-stage multiplier producing the low DATA_W bits of a*b.
// Stage 1 forms two half-width partial products, stage 2 sums them.
// Each stage only updates when its enable is high, so the operands may
// change freely once stage 1 has captured them.
module mult2_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en_s1,
    input  logic              en_s2,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] prod
);

    localparam int HALF = DATA_W / 2;

    logic [DATA_W-1:0] b_lo_ext;
    logic [DATA_W-1:0] b_hi_ext;
    logic [DATA_W-1:0] pp_lo_d, pp_lo_q;
    logic [DATA_W-1:0] pp_hi_d, pp_hi_q;
    logic [DATA_W-1:0] prod_d, prod_q;

    // Split b into halves and compute the next value of each pipeline register.
    always_comb begin
        b_lo_ext = {{(DATA_W - HALF){1'b0}}, b[HALF-1:0]};
        b_hi_ext = {{HALF{1'b0}}, b[DATA_W-1:HALF]};
        pp_lo_d  = pp_lo_q;
        pp_hi_d  = pp_hi_q;
        prod_d   = prod_q;
        if (en_s1) begin
            pp_lo_d = a * b_lo_ext;
            pp_hi_d = a * b_hi_ext;
        end
        if (en_s2) begin
            // Only the low HALF bits of pp_hi survive the shift, which is all
            // a truncated product needs.
            prod_d = pp_lo_q + (pp_hi_q << HALF);
        end
    end

    // Pipeline registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pp_lo_q <= '0;
            pp_hi_q <= '0;
            prod_q  <= '0;
        end else begin
            pp_lo_q <= pp_lo_d;
            pp_hi_q <= pp_hi_d;
            prod_q  <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit. Single-cycle ops resolve combinationally;
// MUL goes through mult2_pipe and holds the pipeline with stall.
//
// Handshake: valid_in marks a live instruction in EX. While stall=1 the
// upstream stages hold their registers and keep presenting the same
// instruction. done=1 means alu_out belongs to the instruction in EX and
// that instruction leaves EX at the end of the cycle. stall and done are
// never high together.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    output logic              stall,
    output logic              done,
    output logic [1:0]        dbg_state
);

    alu_state_e        state_d, state_q;
    logic              mul_req;
    logic              en_s1;
    logic              en_s2;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] alu_res;
    logic [SHAMT_W-1:0] shamt;

    // MUL request seen in IDLE launches the multiplier; MUL1 launches stage 2.
    always_comb begin
        mul_req = valid_in && (alu_control == MUL_OP);
        en_s1   = (state_q == ST_IDLE) && mul_req;
        en_s2   = (state_q == ST_MUL1);
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_req) state_d = ST_MUL1;
            ST_MUL1: state_d = ST_MUL2;
            ST_MUL2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // State register; async reset aborts any multiply immediately.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    mult2_pipe #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk    (clk),
        .arst_n (arst_n),
        .en_s1  (en_s1),
        .en_s2  (en_s2),
        .a      (operand_a),
        .b      (operand_b),
        .prod   (prod)
    );

    // Single-cycle datapath; unused codes yield zero.
    always_comb begin
        shamt   = operand_b[SHAMT_W-1:0];
        alu_res = '0;
        case (alu_control)
            AND_OP: alu_res = operand_a & operand_b;
            OR_OP:  alu_res = operand_a | operand_b;
            ADD_OP: alu_res = operand_a + operand_b;
            SLL_OP: alu_res = operand_a << shamt;
            SRL_OP: alu_res = operand_a >> shamt;
            SUB_OP: alu_res = operand_a - operand_b;
            SLT_OP: alu_res = {{(DATA_W-1){1'b0}},
                               ($signed(operand_a) < $signed(operand_b))};
            default: alu_res = '0;
        endcase
    end

    // Output mux. Gating with arst_n keeps stall/done low during reset even
    // if the held instruction is still a MUL.
    always_comb begin
        alu_out = '0;
        done    = 1'b0;
        stall   = 1'b0;
        if (arst_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (alu_control == MUL_OP) begin
                            stall = 1'b1;
                        end else begin
                            alu_out = alu_res;
                            done    = 1'b1;
                        end
                    end
                end
                ST_MUL1: stall = 1'b1;
                ST_MUL2: begin
                    alu_out = prod;
                    done    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Zero flag for branch resolution and state visibility for debug.
    always_comb begin
        zero      = (alu_out == '0);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: table of single-cycle vectors,
// hand-written multi-cycle MUL sequences, and randomized ops against a
// behavioural model.
module tb_alu_exec_unit;

    logic        clk;
    logic        arst_n;
    logic        flush;
    logic        valid_in;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] alu_out;
    logic        zero;
    logic        stall;
    logic        done;
    logic [1:0]  dbg_state;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_done;
    } vec_t;

    vec_t vecs[12];

    alu_exec_unit dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .flush       (flush),
        .valid_in    (valid_in),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .alu_out     (alu_out),
        .zero        (zero),
        .stall       (stall),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference for every op code.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned p;
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a << sh;
            4'd4: return a >> sh;
            4'd6: return a - b;
            4'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd8: begin
                p = longint'(a) * longint'(b);
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        valid_in    = v;
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
    endtask

    // Issue a MUL at the next cycle and check the stall/done timeline.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit toggle, input string name);
        @(negedge clk);
        drive(1'b1, 4'd8, a, b);
        #1;
        check({name, " stall_T"}, {31'd0, stall}, 32'd1);
        check({name, " done_T"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        if (toggle) begin
            operand_a = ~a;
            operand_b = $urandom;
        end
        #1;
        check({name, " stall_T1"}, {31'd0, stall}, 32'd1);
        check({name, " done_T1"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        #1;
        check({name, " stall_T2"}, {31'd0, stall}, 32'd0);
        check({name, " done_T2"}, {31'd0, done}, 32'd1);
        check({name, " prod"}, alu_out, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        arst_n   = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);

        // Reset state
        #2;
        check("rst alu_out", alu_out, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd1);
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Single-cycle vector table
        vecs[0]  = '{1'b1, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[1]  = '{1'b1, 4'd6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b1, 4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
        vecs[3]  = '{1'b1, 4'd3, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b1};
        vecs[4]  = '{1'b1, 4'd4, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b1};
        vecs[5]  = '{1'b1, 4'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b1};
        vecs[6]  = '{1'b1, 4'd1, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1'b1};
        vecs[7]  = '{1'b1, 4'd5, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 4'd2, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b1, 4'd7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d alu_out", i), alu_out, vecs[i].exp_out);
            check($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
            check($sformatf("vec%0d stall", i), {31'd0, stall}, 32'd0);
            check($sformatf("vec%0d zero", i), {31'd0, zero},
                  {31'd0, (vecs[i].exp_out == 32'd0)});
        end

        // MUL timing and operand isolation
        run_mul(32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0, "mul_basic");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "mul_neg");

        // Async reset in the middle of a MUL
        @(negedge clk);
        drive(1'b1, 4'd8, 32'd7, 32'd9);
        #1;
        check("rstmul stall_T", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        check("rstmul stall_async", {31'd0, stall}, 32'd0);
        check("rstmul done_async", {31'd0, done}, 32'd0);
        drive(1'b1, 4'd2, 32'd2, 32'd3);
        #1;
        arst_n = 1'b1;
        #1;
        check("rstmul add", alu_out, 32'd5);
        check("rstmul add stall", {31'd0, stall}, 32'd0);
        check("rstmul add done", {31'd0, done}, 32'd1);

        // Flush during MUL1 kills the multiply
        @(negedge clk);
        drive(1'b1, 4'd8, 32'd11, 32'd13);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush1 stall_T1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        check("flush1 stall_T2", {31'd0, stall}, 32'd0);
        check("flush1 done_T2", {31'd0, done}, 32'd0);

        // Back-to-back MUL pair
        run_mul(32'd1000, 32'd3000, 32'd3000000, 1'b0, "b2b_a");
        run_mul(32'hDEAD_BEEF, 32'h0001_0001, model(4'd8, 32'hDEAD_BEEF, 32'h0001_0001),
                1'b1, "b2b_b");

        // Flush during MUL2 still reports done that cycle
        @(negedge clk);
        drive(1'b1, 4'd8, 32'd6, 32'd7);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush2 done", {31'd0, done}, 32'd1);
        check("flush2 prod", alu_out, 32'd42);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        check("flush2 after stall", {31'd0, stall}, 32'd0);
        check("flush2 after done", {31'd0, done}, 32'd0);

        // Randomized ops against the model
        for (int n = 0; n < 80; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            bit          got;
            int          lat;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            @(negedge clk);
            drive(1'b1, op, a, b);
            exp_q.push_back(model(op, a, b));
            got = 1'b0;
            lat = 0;
            for (int k = 0; k < 4; k++) begin
                #1;
                if (done) begin
                    check($sformatf("rnd%0d op%0d", n, op), alu_out, exp_q.pop_front());
                    check($sformatf("rnd%0d zero", n), {31'd0, zero}, {31'd0, (alu_out == 32'd0)});
                    got = 1'b1;
                    lat = k;
                    break;
                end
                if (k == 1) begin
                    operand_a = $urandom;
                    operand_b = $urandom;
                end
                @(negedge clk);
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL rnd%0d timeout: done never seen within 4 cycles", n);
                void'(exp_q.pop_front());
            end else begin
                check($sformatf("rnd%0d latency", n), lat, (op == 4'd8) ? 32'd2 : 32'd0);
            end
        end

        drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
